// File: rtl/sd_spi_pkg.sv
// Shared types, command constants and the CRC7 helper for the SD SPI command engine.
package sd_spi_pkg;

  typedef enum logic {
    OP_CMD   = 1'b0,
    OP_DUMMY = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    RT_R1  = 2'd0,
    RT_R1B = 2'd1,
    RT_R37 = 2'd2
  } rtype_e;

  typedef enum logic [1:0] {
    ST_OK           = 2'd0,
    ST_R1_TIMEOUT   = 2'd1,
    ST_BUSY_TIMEOUT = 2'd2
  } status_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DUMMY,
    S_PRE,
    S_CMD,
    S_WAIT_R1,
    S_R1,
    S_TAIL,
    S_BUSY,
    S_POST,
    S_DONE
  } state_e;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int FRAME_BITS = 48;
  localparam int PRE_CLKS   = 8;
  localparam int POST_CLKS  = 8;
  localparam int R1_BITS    = 8;
  localparam int TAIL_BITS  = 32;

  // CRC7 (x^7 + x^3 + 1) over the start/transmit bits, index and argument, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = crc[6] ^ bits[i];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

endpackage

// File: rtl/sd_spi_cmd_engine_sclk_gen.sv
// SCLK divider: emits rise/fall strobes and a mode-0 SCLK that idles low while disabled.
module sd_spi_sclk_gen
  #(
    parameter int CLK_HZ       = 100000000,
    parameter int SLOW_SCLK_HZ = 400000,
    parameter int FAST_SCLK_HZ = 25000000
  )
  (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic fast,
    output logic rise,
    output logic fall,
    output logic sclk
  );

  localparam int HALF_SLOW = CLK_HZ / (2 * SLOW_SCLK_HZ);
  localparam int HALF_FAST = CLK_HZ / (2 * FAST_SCLK_HZ);
  localparam int CNT_W     = $clog2(HALF_SLOW + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_last;
  logic             sclk_reg;
  logic             terminal;

  assign cnt_last = fast ? CNT_W'(HALF_FAST - 1) : CNT_W'(HALF_SLOW - 1);
  assign terminal = en && (cnt_reg == cnt_last);
  assign rise     = terminal && !sclk_reg;
  assign fall     = terminal && sclk_reg;
  assign sclk     = sclk_reg;

  // Half-period counter; toggles SCLK at the terminal count, held cleared (SCLK low) when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (!en) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (terminal) begin
      cnt_reg  <= '0;
      sclk_reg <= ~sclk_reg;
    end else begin
      cnt_reg  <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SD SPI-mode command engine: frames one command, collects the response and reports status.
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
  #(
    parameter int CLK_HZ        = 100000000,
    parameter int SLOW_SCLK_HZ  = 400000,
    parameter int FAST_SCLK_HZ  = 25000000,
    parameter int NCR_MAX_BITS  = 64,
    parameter int BUSY_MAX_BITS = 1000000,
    parameter int DUMMY_CLKS    = 80
  )
  (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [5:0]  req_index,
    input  logic [31:0] req_arg,
    input  logic [1:0]  req_rtype,
    input  logic        req_fast,
    output logic        rsp_valid,
    output logic [7:0]  rsp_r1,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        sd_cclk,
    output logic        sd_cmd,
    input  logic        sd_data0,
    output logic        sd_cs
  );

  localparam int MAX_AB   = (NCR_MAX_BITS > BUSY_MAX_BITS) ? NCR_MAX_BITS : BUSY_MAX_BITS;
  localparam int WAIT_MAX = (MAX_AB > DUMMY_CLKS) ? MAX_AB : DUMMY_CLKS;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int BIT_W    = 6;

  state_e              state_reg, state_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next, bit_cnt_inc;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next, wait_cnt_inc;
  logic [47:0]         frame_reg, frame_next;
  rtype_e              rtype_reg, rtype_next;
  logic                fast_reg, fast_next;
  logic [7:0]          r1_reg, r1_next;
  logic [31:0]         data_reg, data_next;
  status_e             status_reg, status_next;
  logic                cmd_reg, cmd_next;
  logic                miso_meta_reg, miso_sync_reg;
  logic                sclk_en, sclk_rise, sclk_fall;

  // Saturating increments: the counters park at all-ones instead of wrapping.
  assign bit_cnt_inc  = (bit_cnt_reg == '1) ? bit_cnt_reg : bit_cnt_reg + BIT_W'(1);
  assign wait_cnt_inc = (wait_cnt_reg == '1) ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);

  assign sclk_en    = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign req_ready  = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign rsp_valid  = (state_reg == S_DONE);
  assign sd_cs      = !((state_reg == S_PRE) || (state_reg == S_CMD) || (state_reg == S_WAIT_R1) ||
                        (state_reg == S_R1) || (state_reg == S_TAIL) || (state_reg == S_BUSY));
  assign sd_cmd     = cmd_reg;
  assign rsp_r1     = r1_reg;
  assign rsp_data   = data_reg;
  assign rsp_status = status_reg;

  sd_spi_sclk_gen #(
    .CLK_HZ       (CLK_HZ),
    .SLOW_SCLK_HZ (SLOW_SCLK_HZ),
    .FAST_SCLK_HZ (FAST_SCLK_HZ)
  ) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sclk_en),
    .fast  (fast_reg),
    .rise  (sclk_rise),
    .fall  (sclk_fall),
    .sclk  (sd_cclk)
  );

  // Two-flop MISO synchroniser. At the fast rate it makes the sampled stream trail the card
  // by one SCLK; response detection is bit-aligned, so the stream is simply shifted, not corrupted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta_reg <= 1'b1;
      miso_sync_reg <= 1'b1;
    end else begin
      miso_meta_reg <= sd_data0;
      miso_sync_reg <= miso_meta_reg;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      frame_reg    <= '1;
      rtype_reg    <= RT_R1;
      fast_reg     <= 1'b0;
      r1_reg       <= 8'hFF;
      data_reg     <= '0;
      status_reg   <= ST_OK;
      cmd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      frame_reg    <= frame_next;
      rtype_reg    <= rtype_next;
      fast_reg     <= fast_next;
      r1_reg       <= r1_next;
      data_reg     <= data_next;
      status_reg   <= status_next;
      cmd_reg      <= cmd_next;
    end
  end

  // Next-state logic: MOSI moves and phases end on fall strobes, MISO is sampled on rise strobes.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    frame_next    = frame_reg;
    rtype_next    = rtype_reg;
    fast_next     = fast_reg;
    r1_next       = r1_reg;
    data_next     = data_reg;
    status_next   = status_reg;
    cmd_next      = cmd_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (req_valid) begin
          fast_next     = req_fast;
          rtype_next    = rtype_e'(req_rtype);
          frame_next    = {2'b01, req_index, req_arg, crc7({2'b01, req_index, req_arg}), 1'b1};
          r1_next       = 8'hFF;
          data_next     = '0;
          status_next   = ST_OK;
          bit_cnt_next  = '0;
          wait_cnt_next = '0;
          cmd_next      = 1'b1;
          state_next    = (op_e'(req_op) == OP_DUMMY) ? S_DUMMY : S_PRE;
        end else if (state_reg == S_DONE) begin
          state_next = S_IDLE;
        end
      end
      S_DUMMY: begin
        if (sclk_rise) wait_cnt_next = wait_cnt_inc;
        if (sclk_fall && (wait_cnt_reg == WAIT_W'(DUMMY_CLKS))) state_next = S_DONE;
      end
      S_PRE: begin
        if (sclk_rise) bit_cnt_next = bit_cnt_inc;
        if (sclk_fall && (bit_cnt_reg == BIT_W'(PRE_CLKS))) begin
          state_next   = S_CMD;
          bit_cnt_next = '0;
          cmd_next     = frame_reg[47];
          frame_next   = {frame_reg[46:0], 1'b1};
        end
      end
      S_CMD: begin
        if (sclk_rise) bit_cnt_next = bit_cnt_inc;
        if (sclk_fall) begin
          if (bit_cnt_reg == BIT_W'(FRAME_BITS)) begin
            state_next    = S_WAIT_R1;
            bit_cnt_next  = '0;
            wait_cnt_next = '0;
            cmd_next      = 1'b1;
          end else begin
            cmd_next   = frame_reg[47];
            frame_next = {frame_reg[46:0], 1'b1};
          end
        end
      end
      S_WAIT_R1: begin
        if (sclk_rise) begin
          if (!miso_sync_reg) begin
            r1_next      = {r1_reg[6:0], miso_sync_reg};
            bit_cnt_next = BIT_W'(1);
            state_next   = S_R1;
          end else if (wait_cnt_reg == WAIT_W'(NCR_MAX_BITS - 1)) begin
            status_next  = ST_R1_TIMEOUT;
            bit_cnt_next = '0;
            state_next   = S_POST;
          end else begin
            wait_cnt_next = wait_cnt_inc;
          end
        end
      end
      S_R1: begin
        if (sclk_rise) begin
          r1_next      = {r1_reg[6:0], miso_sync_reg};
          bit_cnt_next = bit_cnt_inc;
          if (bit_cnt_reg == BIT_W'(R1_BITS - 1)) begin
            bit_cnt_next  = '0;
            wait_cnt_next = '0;
            case (rtype_reg)
              RT_R37:  state_next = S_TAIL;
              RT_R1B:  state_next = S_BUSY;
              default: state_next = S_POST;
            endcase
          end
        end
      end
      S_TAIL: begin
        if (sclk_rise) begin
          data_next    = {data_reg[30:0], miso_sync_reg};
          bit_cnt_next = bit_cnt_inc;
          if (bit_cnt_reg == BIT_W'(TAIL_BITS - 1)) begin
            bit_cnt_next = '0;
            state_next   = S_POST;
          end
        end
      end
      S_BUSY: begin
        if (sclk_rise) begin
          if (miso_sync_reg) begin
            bit_cnt_next = '0;
            state_next   = S_POST;
          end else if (wait_cnt_reg == WAIT_W'(BUSY_MAX_BITS - 1)) begin
            status_next  = ST_BUSY_TIMEOUT;
            bit_cnt_next = '0;
            state_next   = S_POST;
          end else begin
            wait_cnt_next = wait_cnt_inc;
          end
        end
      end
      S_POST: begin
        if (sclk_rise) bit_cnt_next = bit_cnt_inc;
        if (sclk_fall && (bit_cnt_reg == BIT_W'(POST_CLKS))) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
